// File: rtl/tick_arb_pkg.sv
// Shared types and default sizing for the tick-counted round-robin arbiter.
package tick_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int CW_DEFAULT   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/tick_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after last_owner+1, wrapping.
module rr_pick
    import tick_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    valid
);

    localparam int OW = $clog2(NREQ);

    int idx;

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_owner) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin arbiter holding each grant for len+1 tick cycles, with early release on request drop.
module tick_arbiter
    import tick_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CW-1:0]      len,
    input  logic                    tick,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [CW-1:0]           cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    abort
);

    localparam int OW = $clog2(NREQ);

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [OW-1:0]   owner_n, last_owner, last_owner_n;
    logic [CW-1:0]   cnt_n, limit, limit_n;
    logic            done_n, abort_n;

    logic [OW-1:0]   pick_winner;
    logic            pick_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        owner_n      = owner;
        last_owner_n = last_owner;
        cnt_n        = cnt;
        limit_n      = limit;
        done_n       = 1'b0;
        abort_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n      = GRANT;
                    gnt_n        = NREQ'(1) << pick_winner;
                    owner_n      = pick_winner;
                    last_owner_n = pick_winner;
                    cnt_n        = '0;
                    limit_n      = len[pick_winner*CW +: CW];
                end
            end
            GRANT: begin
                // Early release outranks completion on the same edge.
                if (!req[owner]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    abort_n = 1'b1;
                end else if (tick) begin
                    if (cnt == limit) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            cnt        <= '0;
            limit      <= '0;
            done       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            cnt        <= cnt_n;
            limit      <= limit_n;
            done       <= done_n;
            abort      <= abort_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_tick_arbiter.sv
// Directed bench for tick_arbiter: round-robin order, tick holding, done/abort pulses, reset.
module tb_tick_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic        tick;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [3:0]  cnt;
    logic        busy, done, abort;

    int vectors     = 0;
    int miscompares = 0;

    tick_arbiter #(.NREQ(4), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .tick  (tick),
        .gnt   (gnt),
        .owner (owner),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done),
        .abort (abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [3:0] v);
        len[i*4 +: 4] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_owner,
                             input logic [3:0] e_cnt, input logic e_busy, input logic e_done,
                             input logic e_abort);
        check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, ".owner"}, 32'(owner), 32'(e_owner));
        check({tag, ".cnt"},   32'(cnt),   32'(e_cnt));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
        check({tag, ".done"},  32'(done),  32'(e_done));
        check({tag, ".abort"}, 32'(abort), 32'(e_abort));
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        tick  = 1'b0;
        step();
        step();
        check_all("reset", 4'b0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Single requester, len=3: cnt 0..3 then done.
        reset = 1'b0;
        req   = 4'b0001;
        set_len(0, 4'd3);
        tick  = 1'b1;
        step();
        check_all("r0_grant", 4'b0001, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("r0_cnt1", 32'(cnt), 1);
        step();
        check("r0_cnt2", 32'(cnt), 2);
        step();
        check_all("r0_cnt3", 4'b0001, 2'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        check_all("r0_done", 4'b0000, 2'd0, 4'd3, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        check_all("r0_after", 4'b0000, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0);

        // All requesting, len=0: fresh priority from reset gives 0,1,2,3,0 with gaps.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b1111;
        len   = '0;
        tick  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt",   32'(gnt),   32'(4'b0001 << (k % 4)));
            check("rr_owner", 32'(owner), 32'(k % 4));
            check("rr_busy",  32'(busy),  1);
            step();
            check("rr_gap_gnt",  32'(gnt),  0);
            check("rr_gap_done", 32'(done), 1);
        end
        req = 4'b0000;
        step();
        check_all("rr_idle", 4'b0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Requester 1, len=2, tick toggling: cnt 0,1,1,2,2 then done.
        req = 4'b0010;
        set_len(1, 4'd2);
        tick = 1'b1;
        step();
        check_all("tog_grant", 4'b0010, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1; step(); check("tog_c1", 32'(cnt), 1);
        tick = 1'b0; step(); check("tog_c2", 32'(cnt), 1);
        tick = 1'b1; step(); check("tog_c3", 32'(cnt), 2);
        tick = 1'b0; step(); check_all("tog_c4", 4'b0010, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0);
        tick = 1'b1; step(); check_all("tog_done", 4'b0000, 2'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        step();

        // Requester 2 with len=15, dropped at cnt=5 -> abort, then 3 is served.
        req = 4'b1100;
        set_len(2, 4'd15);
        set_len(3, 4'd0);
        tick = 1'b1;
        step();
        check_all("ab_grant", 4'b0100, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("ab_cnt5", 32'(cnt), 5);
        req = 4'b1000;
        step();
        check_all("ab_abort", 4'b0000, 2'd2, 4'd5, 1'b0, 1'b0, 1'b1);
        step();
        check_all("ab_next3", 4'b1000, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("ab_done3", 4'b0000, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        step();

        // Mid-grant reset at cnt=7 on requester 1, then requester 0 is favoured.
        req = 4'b0110;
        set_len(1, 4'd10);
        step();
        check_all("rst_grant", 4'b0010, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step();
        check("rst_cnt7", 32'(cnt), 7);
        reset = 1'b1;
        step();
        check_all("rst_mid", 4'b0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Post-reset grant to 0 with len=3; len raised to 9 after the grant edge is ignored.
        reset = 1'b0;
        req   = 4'b0111;
        set_len(0, 4'd3);
        step();
        check_all("len_grant", 4'b0001, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        set_len(0, 4'd9);
        step(); check("len_c1", 32'(cnt), 1);
        step(); check("len_c2", 32'(cnt), 2);
        step(); check_all("len_c3", 4'b0001, 2'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(); check_all("len_done", 4'b0000, 2'd0, 4'd3, 1'b0, 1'b1, 1'b0);
        step(); check_all("len_next1", 4'b0010, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
